// File: rtl/dht22_reader_if.sv
// Signal bundle between a DHT22 reader and its requester/consumer.
// The pin pair (dht_in/dht_oe) travels with the bundle so a board wrapper can build the open-drain pad.
interface dht22_reader_if;
  logic        start;
  logic        dht_in;
  logic        dht_oe;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic [7:0]  temp_c_int;
  logic        valid;
  logic        busy;
  logic        err_checksum;
  logic        err_timeout;

  modport master (
    output start, dht_in,
    input  dht_oe, humidity, temperature, temp_c_int, valid, busy,
           err_checksum, err_timeout
  );

  modport slave (
    input  start, dht_in,
    output dht_oe, humidity, temperature, temp_c_int, valid, busy,
           err_checksum, err_timeout
  );
endinterface

// File: rtl/dht22_reader.sv
// DHT22 single-wire master: host start pulse, 40-bit frame decode, checksum check.
// All protocol timing is counted in 1 us ticks derived from CLK_HZ.
module dht22_reader #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned START_LOW_US  = 1000,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned HOLDOFF_US    = 2_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  dht22_reader_if.slave bus
);

  localparam int unsigned TICK_DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_A    = (HOLDOFF_US > START_LOW_US) ? HOLDOFF_US : START_LOW_US;
  localparam int unsigned CNT_MAX  = (MAX_A > TIMEOUT_US + 1) ? MAX_A : TIMEOUT_US + 1;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, HOLDOFF
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             sync1, sync2, sync_q;
  logic             rise, fall, edge_hit;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_idx;
  logic [39:0]      frame;
  logic             ready;
  logic             accept;
  logic [7:0]       sum_b;
  logic [14:0]      quot;
  logic [7:0]       tint_next;
  logic             bit_one;

  assign tick    = (div_cnt == DIV_W'(TICK_DIV - 1));
  // ready masks a start that coincides with the first clock after reset release
  assign accept  = (state == IDLE) && ready && bus.start;
  assign rise    = sync2 && !sync_q;
  assign fall    = !sync2 && sync_q;
  assign bit_one = (cnt >= CNT_W'(BIT_THRESH_US));

  assign sum_b     = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign quot      = frame[22:8] / 15'd10;
  assign tint_next = frame[23] ? '0 : ((quot > 15'd255) ? 8'hFF : quot[7:0]);

  always_comb begin
    edge_hit = 1'b0;
    case (state)
      RELEASE, RESP_HIGH, BIT_HIGH: edge_hit = fall;
      RESP_LOW, BIT_LOW:            edge_hit = rise;
      default:                      edge_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync1  <= bus.dht_in;
      sync2  <= sync1;
      sync_q <= sync2;
    end
  end

  // Divider restarts on acceptance so the start pulse is an exact tick multiple
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_cnt <= '0;
    else if (accept || tick) div_cnt <= '0;
    else                     div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      frame            <= '0;
      ready            <= 1'b0;
      bus.dht_oe       <= 1'b0;
      bus.humidity     <= '0;
      bus.temperature  <= '0;
      bus.temp_c_int   <= '0;
      bus.valid        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.err_checksum <= 1'b0;
      bus.err_timeout  <= 1'b0;
    end else begin
      ready     <= 1'b1;
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state            <= START_LOW;
            cnt              <= '0;
            bus.dht_oe       <= 1'b1;
            bus.busy         <= 1'b1;
            bus.err_checksum <= 1'b0;
            bus.err_timeout  <= 1'b0;
          end
        end
        START_LOW: begin
          if (tick) begin
            if (cnt == CNT_W'(START_LOW_US - 1)) begin
              state      <= RELEASE;
              cnt        <= '0;
              bus.dht_oe <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: begin
          // cnt doubles as the dwell timer and the BIT_HIGH pulse width
          if (edge_hit) begin
            cnt <= '0;
            case (state)
              RELEASE:  state <= RESP_LOW;
              RESP_LOW: state <= RESP_HIGH;
              RESP_HIGH: begin
                state   <= BIT_LOW;
                bit_idx <= '0;
              end
              BIT_LOW:  state <= BIT_HIGH;
              BIT_HIGH: begin
                frame <= {frame[38:0], bit_one};
                if (bit_idx == 6'd39) begin
                  state <= CHECK;
                end else begin
                  bit_idx <= bit_idx + 1'b1;
                  state   <= BIT_LOW;
                end
              end
              default: state <= IDLE;
            endcase
          end else if (tick) begin
            if (cnt == CNT_W'(TIMEOUT_US)) begin
              state           <= HOLDOFF;
              cnt             <= '0;
              bus.err_timeout <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          state <= HOLDOFF;
          cnt   <= '0;
          if (sum_b == frame[7:0]) begin
            bus.humidity    <= frame[39:24];
            bus.temperature <= frame[23:8];
            bus.temp_c_int  <= tint_next;
            bus.valid       <= 1'b1;
          end else begin
            bus.err_checksum <= 1'b1;
          end
        end
        HOLDOFF: begin
          if (tick) begin
            if (cnt == CNT_W'(HOLDOFF_US - 1)) begin
              state    <= IDLE;
              cnt      <= '0;
              bus.busy <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht22_reader.sv
// Bench for dht22_reader: behavioural sensor on the open-drain line, a table of
// directed frames, randomized frames checked against an arithmetic reference model.
module tb_dht22_reader;
  localparam int unsigned START_LOW = 100;
  localparam int unsigned TIMEOUT   = 200;
  localparam int unsigned HOLDOFF   = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sensor_line = 1'b1;

  dht22_reader_if bus ();
  assign bus.dht_in = bus.dht_oe ? 1'b0 : sensor_line;

  dht22_reader #(
    .CLK_HZ       (1_000_000),
    .START_LOW_US (START_LOW),
    .BIT_THRESH_US(50),
    .TIMEOUT_US   (TIMEOUT),
    .HOLDOFF_US   (HOLDOFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int oe_rises = 0;
  logic oe_q = 1'b0;

  // published-value model state
  int m_hum = 0, m_temp = 0, m_tint = 0;

  always @(negedge clk) begin
    if (bus.valid) vcount <= vcount + 1;
    if (bus.dht_oe && !oe_q) oe_rises <= oe_rises + 1;
    oe_q <= bus.dht_oe;
  end

  typedef struct {
    logic [39:0] frame;
    bit          ok;
    int          hum;
    int          temp;
    int          tint;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic [39:0] f, output bit ok);
    int b[5];
    int t;
    for (int i = 0; i < 5; i++) b[i] = int'(f[39 - 8*i -: 8]);
    ok = (((b[0] + b[1] + b[2] + b[3]) % 256) == b[4]);
    if (ok) begin
      m_hum  = b[0] * 256 + b[1];
      t      = b[2] * 256 + b[3];
      m_temp = t;
      if (t >= 32768)     m_tint = 0;
      else if (t / 10 > 255) m_tint = 255;
      else                m_tint = t / 10;
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    sensor_line = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", bus.busy, 0);
  endtask

  task automatic do_start();
    int w = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("accept_busy", bus.busy, 1);
    check("err_cleared", {bus.err_checksum, bus.err_timeout}, 0);
    while (bus.dht_oe && w < int'(START_LOW) + 50) begin
      if (w == 5) bus.start = 1'b1;
      if (w == 6) bus.start = 1'b0;
      @(negedge clk);
      w++;
    end
    check("start_low_width", w, START_LOW);
  endtask

  task automatic send_bits(input logic [39:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 20) bus.start = 1'b1;
      hold(1'b0, 1);
      bus.start = 1'b0;
      hold(1'b0, $urandom_range(19, 49));
      hold(1'b1, f[39 - i] ? $urandom_range(60, 90) : $urandom_range(10, 40));
    end
  endtask

  task automatic run_frame(input logic [39:0] f, input bit ok, input int eh,
                           input int et, input int eti, input string tag);
    int v0, r0, lat;
    wait_idle();
    #1;
    v0 = vcount;
    r0 = oe_rises;
    do_start();
    hold(1'b1, 20);
    hold(1'b0, 80);
    hold(1'b1, 80);
    send_bits(f, 39);
    hold(1'b0, 30);
    hold(1'b1, f[0] ? 75 : 25);
    sensor_line = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid && lat == 0) lat = k;
    end
    @(negedge clk);
    hold(1'b0, 30);
    sensor_line = 1'b1;
    #1;
    check({tag, ":latency"}, lat, ok ? 4 : 0);
    check({tag, ":valid_pulses"}, vcount - v0, ok ? 1 : 0);
    check({tag, ":humidity"}, bus.humidity, eh);
    check({tag, ":temperature"}, bus.temperature, et);
    check({tag, ":temp_c_int"}, bus.temp_c_int, eti);
    check({tag, ":err_checksum"}, bus.err_checksum, ok ? 0 : 1);
    check({tag, ":err_timeout"}, bus.err_timeout, 0);
    check({tag, ":busy_in_holdoff"}, bus.busy, 1);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_idle();
    #1;
    check({tag, ":one_start"}, oe_rises - r0, 1);
  endtask

  task automatic run_model_frame(input logic [39:0] f, input string tag);
    bit ok;
    model_apply(f, ok);
    run_frame(f, ok, m_hum, m_temp, m_tint, tag);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] f;
    logic [7:0]  b[5];
    int v0, r0, k;

    tbl[0] = '{40'h02_8C_01_5F_EE, 1'b1, 652,   351,   35};
    tbl[1] = '{40'h01_90_80_65_76, 1'b1, 400,   32869, 0};
    tbl[2] = '{40'h02_8C_01_5F_EF, 1'b0, 400,   32869, 0};
    tbl[3] = '{40'h03_E8_06_72_63, 1'b1, 1000,  1650,  165};
    tbl[4] = '{40'hFF_FF_7F_FF_7C, 1'b1, 65535, 32767, 255};
    tbl[5] = '{40'h00_00_00_09_09, 1'b1, 0,     9,     0};

    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_oe", bus.dht_oe, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_data", {bus.humidity, bus.temperature, bus.temp_c_int}, 0);
    check("reset_flags", {bus.valid, bus.err_checksum, bus.err_timeout}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].frame, tbl[i].ok, tbl[i].hum, tbl[i].temp, tbl[i].tint,
                $sformatf("vec%0d", i));
      m_hum  = tbl[i].hum;
      m_temp = tbl[i].temp;
      m_tint = tbl[i].tint;
    end

    // silent sensor: line never pulled low after release
    wait_idle();
    #1;
    v0 = vcount;
    r0 = oe_rises;
    do_start();
    k = 0;
    while (!bus.err_timeout && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("timeout_set", bus.err_timeout, 1);
    check("timeout_low", (k >= int'(TIMEOUT) && k <= int'(TIMEOUT) + 2) ? 1 : 0, 1);
    check("timeout_oe", bus.dht_oe, 0);
    check("timeout_hum", bus.humidity, m_hum);
    check("timeout_temp", bus.temperature, m_temp);
    wait_idle();
    #1;
    check("timeout_no_valid", vcount - v0, 0);
    check("timeout_one_start", oe_rises - r0, 1);
    check("timeout_sticky", bus.err_timeout, 1);

    run_model_frame(40'h02_8C_01_5F_EE, "after_timeout");

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom_range(0, 255));
      b[4] = b[0] + b[1] + b[2] + b[3];
      if ($urandom_range(0, 3) == 0) b[4] = b[4] + 8'd1;
      f = {b[0], b[1], b[2], b[3], b[4]};
      run_model_frame(f, $sformatf("rand%0d", i));
    end

    run_model_frame(40'h02_8C_01_5F_EE, "pre_reset");

    // reset asserted in the middle of a data bit's high phase
    wait_idle();
    do_start();
    hold(1'b1, 20);
    hold(1'b0, 80);
    hold(1'b1, 80);
    send_bits(40'h02_8C_01_5F_EE, 10);
    hold(1'b0, 30);
    hold(1'b1, 10);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_oe", bus.dht_oe, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_hum", bus.humidity, 0);
    check("midrst_temp", bus.temperature, 0);
    check("midrst_tint", bus.temp_c_int, 0);
    @(negedge clk);
    #1;
    r0 = oe_rises;
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("start_at_reset_busy", bus.busy, 0);
    check("start_at_reset_oe", oe_rises - r0, 0);
    m_hum  = 0;
    m_temp = 0;
    m_tint = 0;
    run_model_frame(40'h02_8C_01_5F_EE, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
